// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide synchronous memory between the CPU
// port and the debug/loader port. Word accesses become two byte cycles,
// low byte first (little-endian, {mem[a+1], mem[a]}).
// Ports:
//   clock, reset (async, active-high)
//   cpu_* / dbg_* : req, we, word, addr, wdata in; ack, rdata out
//   mem_addr, mem_we, mem_wdata out; mem_rdata in (one-cycle read latency)
//   busy (not IDLE), grant (0 = CPU, 1 = debug)
// Option: MEM_ARB_FAIR_EN selects round-robin; otherwise the CPU has
// fixed priority.
module mem_arbiter #(
  parameter int AW = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic          cpu_word,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_wdata,
  output logic          cpu_ack,
  output logic [15:0]   cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic          dbg_word,
  input  logic [AW-1:0] dbg_addr,
  input  logic [15:0]   dbg_wdata,
  output logic          dbg_ack,
  output logic [15:0]   dbg_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          grant
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_DONE,
    S_ACK
  } state_t;

  state_t        state;
  logic          we_q;
  logic          word_q;
  logic [AW-1:0] addr_q;
  logic [15:0]   wdata_q;
  logic [15:0]   result;

  logic          any_req;
  logic          pick_dbg;
  logic          sel_we;
  logic          sel_word;
  logic [AW-1:0] sel_addr;
  logic [15:0]   sel_wdata;

  assign any_req = cpu_req | dbg_req;

`ifdef MEM_ARB_FAIR_EN
  // Port granted most recently; debug after reset so the CPU wins first.
  logic last_dbg;

  assign pick_dbg = dbg_req & (~cpu_req | ~last_dbg);
`else
  assign pick_dbg = dbg_req & ~cpu_req;
`endif

  assign sel_we    = pick_dbg ? dbg_we    : cpu_we;
  assign sel_word  = pick_dbg ? dbg_word  : cpu_word;
  assign sel_addr  = pick_dbg ? dbg_addr  : cpu_addr;
  assign sel_wdata = pick_dbg ? dbg_wdata : cpu_wdata;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      we_q      <= 1'b0;
      word_q    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      result    <= '0;
      grant     <= 1'b0;
      cpu_ack   <= 1'b0;
      dbg_ack   <= 1'b0;
      cpu_rdata <= '0;
      dbg_rdata <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
`ifdef MEM_ARB_FAIR_EN
      last_dbg  <= 1'b1;
`endif
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any_req) begin
            grant     <= pick_dbg;
            we_q      <= sel_we;
            word_q    <= sel_word;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            // Outputs are registered, so the low-byte
            // cycle is presented on entry to LO.
            mem_addr  <= sel_addr;
            mem_we    <= sel_we;
            mem_wdata <= sel_wdata[7:0];
`ifdef MEM_ARB_FAIR_EN
            last_dbg  <= pick_dbg;
`endif
            state     <= S_LO;
          end
        end
        S_LO: begin
          if (word_q) begin
            mem_addr  <= addr_q + {{(AW-1){1'b0}}, 1'b1};
            mem_we    <= we_q;
            mem_wdata <= wdata_q[15:8];
            state     <= S_HI;
          end else begin
            mem_we <= 1'b0;
            state  <= S_DONE;
          end
        end
        S_HI: begin
          // Low byte of a word read is on mem_rdata now.
          if (!we_q) begin
            result[7:0] <= mem_rdata;
          end
          mem_we <= 1'b0;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (!we_q) begin
            if (word_q) begin
              result[15:8] <= mem_rdata;
            end else begin
              result <= {8'h00, mem_rdata};
            end
          end
          state <= S_ACK;
        end
        S_ACK: begin
          if (grant) begin
            dbg_ack   <= 1'b1;
            dbg_rdata <= result;
          end else begin
            cpu_ack   <= 1'b1;
            cpu_rdata <= result;
          end
          state <= S_IDLE;
        end
        default: begin
          mem_we <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random accesses on both ports against a
// byte-array memory and a shadow reference memory.
module tb_mem_arbiter;

  localparam int AW = 16;

  logic          clock;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_word;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic          cpu_ack;
  logic [15:0]   cpu_rdata;
  logic          dbg_req, dbg_we, dbg_word;
  logic [AW-1:0] dbg_addr;
  logic [15:0]   dbg_wdata;
  logic          dbg_ack;
  logic [15:0]   dbg_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          busy;
  logic          grant;

  mem_arbiter #(.AW(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_word  (cpu_word),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .dbg_req   (dbg_req),
    .dbg_we    (dbg_we),
    .dbg_word  (dbg_word),
    .dbg_addr  (dbg_addr),
    .dbg_wdata (dbg_wdata),
    .dbg_ack   (dbg_ack),
    .dbg_rdata (dbg_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .grant     (grant)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory macro model with a preload path used only during reset.
  logic [7:0]  mem [0:65535];
  logic        pl_en;
  logic [15:0] pl_addr;
  logic [7:0]  pl_data;

  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Reference model state.
  logic [7:0]  ref_mem [0:65535];
  logic [15:0] exp_rd [2];
  bit          rd_ok [2];

  int total;
  int passed;
  int fails;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input bit p, input bit r, input bit we,
                          input bit wd, input logic [15:0] a,
                          input logic [15:0] d);
    if (p) begin
      dbg_req = r; dbg_we = we; dbg_word = wd;
      dbg_addr = a; dbg_wdata = d;
    end else begin
      cpu_req = r; cpu_we = we; cpu_word = wd;
      cpu_addr = a; cpu_wdata = d;
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    @(negedge clock);
    pl_en = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cpu_ack"}, cpu_ack, 0);
    check({tag, "_dbg_ack"}, dbg_ack, 0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 0);
    check({tag, "_dbg_rdata"}, dbg_rdata, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant, 0);
  endtask

  // One access on port p from an idle arbiter; starts and ends at negedge.
  task automatic access(input bit p, input bit we, input bit wd,
                        input logic [15:0] a, input logic [15:0] d);
    logic [15:0] a1, exp;
    logic [15:0] addr_lo, addr_hi;
    logic        we_lo, we_hi;
    logic [7:0]  wd_lo, wd_hi;
    int cnt, pulses, q;
    bit got, other_ack;
    a1 = a + 16'd1;
    q = p ? 0 : 1;
    exp = wd ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
    addr_lo = '0; addr_hi = '0; we_lo = 0; we_hi = 0;
    wd_lo = '0; wd_hi = '0;
    cnt = 0; pulses = 0; got = 0; other_ack = 0;
    set_port(p, 1'b1, we, wd, a, d);
    while (!got && cnt < 20) begin
      @(negedge clock);
      cnt++;
      if (mem_we) pulses++;
      if (p ? cpu_ack : dbg_ack) other_ack = 1;
      if (cnt == 1) begin
        addr_lo = mem_addr; we_lo = mem_we; wd_lo = mem_wdata;
        check("grant", grant, p);
        check("busy", busy, 1);
      end
      if (cnt == 2) begin
        addr_hi = mem_addr; we_hi = mem_we; wd_hi = mem_wdata;
      end
      if (p ? dbg_ack : cpu_ack) got = 1;
    end
    set_port(p, 1'b0, we, wd, a, d);
    check("ack_seen", got, 1);
    check("latency", cnt - 1, wd ? 4 : 3);
    check("addr_lo", addr_lo, a);
    check("we_lo", we_lo, we);
    check("we_pulses", pulses, we ? (wd ? 2 : 1) : 0);
    check("other_ack", other_ack, 0);
    if (wd) begin
      check("addr_hi", addr_hi, a1);
      check("we_hi", we_hi, we);
    end
    if (we) begin
      check("wdata_lo", wd_lo, d[7:0]);
      if (wd) check("wdata_hi", wd_hi, d[15:8]);
      ref_mem[a] = d[7:0];
      if (wd) ref_mem[a1] = d[15:8];
      rd_ok[p] = 0;
    end else begin
      check("rdata", p ? dbg_rdata : cpu_rdata, exp);
      exp_rd[p] = exp;
      rd_ok[p] = 1;
    end
    if (rd_ok[q]) check("other_rdata", q ? dbg_rdata : cpu_rdata, exp_rd[q]);
  endtask

  initial begin
    int d_at, c_at, n, prev, mism;
    bit seen_ack;
    bit last, win;
    bit exp_who [5];
    logic [15:0] exp_d, exp_c, exp41;
    total = 0; passed = 0; fails = 0;
    reset = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    set_port(0, 0, 0, 0, 16'h0, 16'h0);
    set_port(1, 0, 0, 0, 16'h0, 16'h0);
    @(negedge clock);
    for (int i = 0; i < 16'h0400; i++)
      preload(16'(i), 8'($urandom_range(0, 255)));
    for (int i = 16'hFC00; i <= 16'hFFFF; i++)
      preload(16'(i), 8'($urandom_range(0, 255)));
    preload(16'h0010, 8'h34);
    preload(16'h0011, 8'h12);
    check_reset_vals("rst");
    reset = 1'b0;
    exp_rd[0] = 0; exp_rd[1] = 0; rd_ok[0] = 1; rd_ok[1] = 1;
    @(negedge clock);

    // Word read.
    access(0, 0, 1, 16'h0010, 16'h0000);
    check("tp_word_read", cpu_rdata, 16'h1234);

    // Debug byte write, CPU byte read back.
    access(1, 1, 0, 16'h0200, 16'h00A5);
    access(0, 0, 0, 16'h0200, 16'h0000);
    check("tp_byte_read", cpu_rdata, 16'h00A5);

    // Word write across the top of the address space.
    access(0, 1, 1, 16'hFFFF, 16'hBEEF);
    check("wrap_lo", mem[16'hFFFF], 8'hEF);
    check("wrap_hi", mem[16'h0000], 8'hBE);

    // CPU request arriving while debug is mid-access.
    exp_d = {8'h00, ref_mem[16'h0020]};
    exp_c = {8'h00, ref_mem[16'h0021]};
    set_port(1, 1, 0, 0, 16'h0020, 16'h0);
    d_at = -1; c_at = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      if (k == 1) check("ovl_grant_dbg", grant, 1);
      if (k == 2) set_port(0, 1, 0, 0, 16'h0021, 16'h0);
      if (k == 5) check("ovl_grant_cpu", grant, 0);
      if (dbg_ack && d_at < 0) begin
        d_at = k; dbg_req = 0;
        check("ovl_dbg_rdata", dbg_rdata, exp_d);
      end
      if (cpu_ack && c_at < 0) begin
        c_at = k; cpu_req = 0;
        check("ovl_cpu_rdata", cpu_rdata, exp_c);
        check("ovl_dbg_hold", dbg_rdata, exp_d);
      end
    end
    check("ovl_dbg_at", d_at, 4);
    check("ovl_cpu_at", c_at, 8);
    exp_rd[0] = exp_c; exp_rd[1] = exp_d; rd_ok[0] = 1; rd_ok[1] = 1;

    // Random single-port traffic.
    for (int i = 0; i < 40; i++) begin
      bit p, we, wd;
      logic [15:0] a, d;
      p = 1'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      wd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = 16'hFFFF;
      else if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(0, 16'h03FE));
      else a = 16'hFC00 + 16'($urandom_range(0, 16'h03FF));
      d = 16'($urandom);
      access(p, we, wd, a, d);
    end

    // Reset during the high-byte cycle of a word write.
    exp41 = {8'h00, ref_mem[16'h0041]};
    set_port(0, 1, 1, 1, 16'h0040, 16'h5678);
    @(negedge clock);
    @(negedge clock);
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_reset_vals("midrst");
    cpu_req = 0;
    @(negedge clock);
    reset = 1'b0;
    seen_ack = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (cpu_ack || dbg_ack) seen_ack = 1;
    end
    check("midrst_no_ack", seen_ack, 0);
    check("midrst_lo", mem[16'h0040], 8'h78);
    check("midrst_hi", mem[16'h0041], exp41[7:0]);
    ref_mem[16'h0040] = 8'h78;

    // Both ports requesting continuously from reset.
    last = 1;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
`ifdef MEM_ARB_FAIR_EN
        win = ~last;
`else
        win = 0;
`endif
      end else begin
        win = 1;
      end
      exp_who[i] = win;
      last = win;
    end
    exp_c = {ref_mem[16'h0011], ref_mem[16'h0010]};
    exp_d = {8'h00, ref_mem[16'h0020]};
    set_port(0, 1, 0, 1, 16'h0010, 16'h0);
    set_port(1, 1, 0, 0, 16'h0020, 16'h0);
    n = 0; prev = 0;
    for (int k = 1; k <= 40 && n < 5; k++) begin
      @(negedge clock);
      if (cpu_ack || dbg_ack) begin
        check("rr_one_ack", cpu_ack && dbg_ack, 0);
        check("rr_who", dbg_ack, exp_who[n]);
        check("rr_interval", k - prev, exp_who[n] ? 4 : 5);
        if (dbg_ack) check("rr_dbg_rdata", dbg_rdata, exp_d);
        else check("rr_cpu_rdata", cpu_rdata, exp_c);
        prev = k;
        n++;
        if (n == 4) cpu_req = 0;
        if (n == 5) dbg_req = 0;
      end
    end
    cpu_req = 0; dbg_req = 0;
    check("rr_count", n, 5);
    repeat (6) @(negedge clock);

    mism = 0;
    for (int i = 0; i < 16'h0400; i++)
      if (mem[i] !== ref_mem[i]) mism++;
    for (int i = 16'hFC00; i <= 16'hFFFF; i++)
      if (mem[i] !== ref_mem[i]) mism++;
    check("final_mem", mism, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-port, byte-wide main memory between the CPU's data/fetch port and a debug/loader port. Each requester issues byte or 16-bit little-endian word reads and writes through a req/ack handshake. The arbiter sequences each word access into two byte cycles, low byte first, matching the CPU's `{mem[a+1], mem[a]}` layout. It sits between `cpu` and the memory macro and replaces the CPU's direct memory array.

## Interface
Parameters:
- `AW`, 16, memory address width; all address arithmetic is modulo 2^AW.

Ports:
- `clock`  in  1  system clock; all state changes on posedge.
- `reset`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  CPU request; held high until `cpu_ack`.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_word`  in  1  1 = 16-bit access, 0 = byte access.
- `cpu_addr`  in  AW  byte address (word: low byte address).
- `cpu_wdata`  in  16  write data; byte writes use [7:0].
- `cpu_ack`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  16  read data, valid while `cpu_ack`=1; byte reads zero-extended.
- `dbg_req`, `dbg_we`, `dbg_word`, `dbg_addr`, `dbg_wdata`, `dbg_ack`, `dbg_rdata`: identical set for the debug/loader port.
- `mem_addr`  out  AW  memory byte address.
- `mem_we`  out  1  memory byte write strobe.
- `mem_wdata`  out  8  memory write byte.
- `mem_rdata`  in  8  memory read byte; synchronous, valid one cycle after the address is presented.
- `busy`  out  1  high in every state except IDLE.
- `grant`  out  1  0 = CPU owns the access, 1 = debug; meaningful while `busy`.

## Operation
- FSM states: IDLE, LO, HI, DONE, ACK.
- IDLE:
  - If any req is high, pick a winner, latch its we/word/addr/wdata and `grant`, then go to LO.
  - Otherwise stay in IDLE.
- LO: drive `mem_addr`=addr, `mem_we`=we, `mem_wdata`=wdata[7:0]. Go to HI if word, else DONE.
- HI:
  - Drive `mem_addr`=addr+1 (wraps 2^AW-1 to 0), `mem_we`=we, `mem_wdata`=wdata[15:8].
  - Capture `mem_rdata` (the low byte) into the result register. Go to DONE.
- DONE:
  - Capture `mem_rdata` into result[15:8] for a word, or result[7:0] with [15:8]=0 for a byte. Writes ignore it.
  - Go to ACK.
- ACK: assert the granted port's ack (registered) with rdata from the result register. Go to IDLE.
- `mem_we`=0 in IDLE, DONE, ACK. `mem_addr` and `mem_wdata` hold their last values outside LO/HI.
- rdata of the non-granted port is unchanged. rdata after a write is don't-care.
- The requester drops req in the cycle after ack. A req still high in IDLE is a new access.
- Request fields are latched at grant; later changes are ignored until ack.
- A request arriving while `busy` waits. No request is dropped.

## Timing
- Request sampled at IDLE edge E0.
- Word access: memory cycles at E1 (LO) and E2 (HI); ack high during the cycle after E4 (4-cycle latency).
- Byte access: ack high during the cycle after E3 (3-cycle latency).
- Throughput: back-to-back word accesses every 5 cycles, byte accesses every 4.
- Reset values: `cpu_ack`=`dbg_ack`=0, `cpu_rdata`=`dbg_rdata`=0, `mem_addr`=0, `mem_we`=0, `mem_wdata`=0, `busy`=0, `grant`=0, state IDLE, round-robin pointer = debug (CPU wins first).
- Reset mid-access aborts immediately. `mem_we` drops asynchronously and no ack is issued. A word write interrupted after LO leaves only its low byte written.

## Configuration
- `MEM_ARB_FAIR_EN` defined:
  - Round-robin arbitration. On simultaneous requests, the port not granted last wins.
  - The pointer updates on every grant.
- Undefined:
  - Fixed priority; CPU always wins.
  - The debug port is granted only in an IDLE cycle with `cpu_req`=0.

## Test plan
- CPU word read at 0x0010, mem[0x10]=0x34, mem[0x11]=0x12 -> `cpu_ack` 4 cycles after sample, `cpu_rdata`=0x1234; `mem_addr` 0x0010 then 0x0011; `mem_we`=0.
- Debug byte write 0xA5 to 0x0200, then CPU byte read 0x0200 -> one `mem_we` pulse with `mem_wdata`=0xA5; CPU read returns 0x00A5 after 3 cycles.
- CPU word write 0xBEEF at 0xFFFF -> mem[0xFFFF]=0xEF, mem[0x0000]=0xBE (address wrap).
- Both req high from reset with continuous re-requests -> FAIR_EN: grants CPU, debug, CPU, debug; without it: CPU only, `dbg_ack` never asserted until `cpu_req` drops.
- `reset` asserted in HI of word write 0x5678 to 0x0040 -> mem[0x40]=0x78, mem[0x41] unchanged, no ack; outputs at reset values the same cycle.
- CPU req raised while debug access is in DONE -> CPU granted on the IDLE edge after debug ACK; `dbg_rdata` holds its value.
